// File: rtl/pc_sequencer_if.sv
// Next-PC controller bus: redirect requests in, PC register controls out.
// master drives requests and observes controls; slave is the sequencer.
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        br_taken;
  logic [31:0] br_target;
  logic        j_en;
  logic [31:0] j_target;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        eret;
  logic [31:0] epc_in;
  logic        exc_req;
  logic        busy;
  logic        halt;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        exc_ack;
  logic        timeout;
  logic [1:0]  seq_state;

  modport master (
    output pc_cur, br_taken, br_target,
    output j_en, j_target, jr_en, jr_target,
    output eret, epc_in, exc_req, busy, halt,
    input  pc_ena, pc_next, exc_ack,
    input  timeout, seq_state
  );

  modport slave (
    input  pc_cur, br_taken, br_target,
    input  j_en, j_target, jr_en, jr_target,
    input  eret, epc_in, exc_req, busy, halt,
    output pc_ena, pc_next, exc_ack,
    output timeout, seq_state
  );
endinterface

// File: rtl/pc_sequencer.sv
// CPU54 next-PC sequencer: picks the fetch address, freezes on MUL/DIV
// stalls, queues exceptions raised mid-stall and supports a sticky halt.
module pc_sequencer #(
  parameter logic [31:0] EXC_VEC   = 32'h0000_0004,
  parameter int          STALL_MAX = 64,
  parameter int          CNT_W     = 7
) (
  input logic          clk,
  input logic          rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    TRAP  = 2'b10,
    HALT  = 2'b11
  } state_t;

  state_t             state;
  logic               pend_exc;
  logic [CNT_W-1:0]   stall_cnt;

  logic [31:0] seq_pc;
  logic [31:0] sel_pc;
  logic        wd_hit;

  function automatic logic [31:0] tgt(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

  assign seq_pc = bus.pc_cur + 32'd4;
  assign wd_hit = (stall_cnt == CNT_W'(STALL_MAX));

  always_comb begin
    sel_pc = seq_pc;
    if (bus.exc_req)       sel_pc = tgt(EXC_VEC);
    else if (bus.eret)     sel_pc = tgt(bus.epc_in);
    else if (bus.jr_en)    sel_pc = tgt(bus.jr_target);
    else if (bus.j_en)     sel_pc = tgt(bus.j_target);
    else if (bus.br_taken) sel_pc = tgt(bus.br_target);
  end

  always_comb begin
    bus.pc_ena  = 1'b0;
    bus.exc_ack = 1'b0;
    bus.timeout = 1'b0;
    bus.pc_next = seq_pc;
    if (!rst) begin
      unique case (state)
        RUN: begin
          bus.pc_next = sel_pc;
          if (!bus.halt && !bus.busy) begin
            bus.pc_ena  = 1'b1;
            bus.exc_ack = bus.exc_req;
          end
        end
        STALL: begin
          bus.pc_next = sel_pc;
          if (!bus.halt) begin
            if (!bus.busy && !pend_exc) begin
              bus.pc_ena  = 1'b1;
              bus.exc_ack = bus.exc_req;
            end
            bus.timeout = bus.busy && wd_hit;
          end
        end
        TRAP: begin
          bus.pc_ena  = 1'b1;
          bus.exc_ack = 1'b1;
          bus.pc_next = tgt(EXC_VEC);
        end
        HALT: bus.pc_next = seq_pc;
        default: bus.pc_next = seq_pc;
      endcase
    end
  end

  assign bus.seq_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pend_exc  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.halt) begin
            state <= HALT;
          end else if (bus.busy) begin
            state     <= STALL;
            stall_cnt <= CNT_W'(1);
            pend_exc  <= bus.exc_req;
          end
        end
        STALL: begin
          stall_cnt <= stall_cnt + 1'b1;
          if (bus.exc_req) pend_exc <= 1'b1;
          if (bus.halt) begin
            state    <= HALT;
            pend_exc <= 1'b0;
          end else if (!bus.busy) begin
            if (pend_exc) begin
              state <= TRAP;
            end else begin
              state     <= RUN;
              pend_exc  <= 1'b0;
              stall_cnt <= '0;
            end
          end else if (wd_hit) begin
            // watchdog expiry is delivered as a queued exception
            pend_exc <= 1'b1;
            state    <= TRAP;
          end
        end
        TRAP: begin
          pend_exc  <= 1'b0;
          stall_cnt <= '0;
          state     <= RUN;
        end
        HALT: state <= HALT;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: per-cycle expectations are queued
// as stimulus is driven and popped when outputs settle at negedge.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if bus();

  pc_sequencer #(
    .EXC_VEC(32'h0000_0004),
    .STALL_MAX(64),
    .CNT_W(7)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  localparam logic [1:0] S_RUN = 2'b00;
  localparam logic [1:0] S_STL = 2'b01;
  localparam logic [1:0] S_TRP = 2'b10;
  localparam logic [1:0] S_HLT = 2'b11;

  typedef struct packed {
    logic        ena;
    logic        ack;
    logic        tmo;
    logic [1:0]  st;
    logic [31:0] nx;
    logic        care;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  exp_t g;
  int checks = 0;
  int errors = 0;

  function automatic exp_t mk(
    input logic ena, input logic ack,
    input logic tmo, input logic [1:0] st,
    input logic [31:0] nx, input logic care
  );
    return {ena, ack, tmo, st, nx, care};
  endfunction

  function automatic exp_t obs();
    return {bus.pc_ena, bus.exc_ack,
            bus.timeout, bus.seq_state,
            bus.pc_next, 1'b1};
  endfunction

  task automatic idle();
    bus.br_taken  = 1'b0;
    bus.br_target = 32'h0;
    bus.j_en      = 1'b0;
    bus.j_target  = 32'h0;
    bus.jr_en     = 1'b0;
    bus.jr_target = 32'h0;
    bus.eret      = 1'b0;
    bus.epc_in    = 32'h0;
    bus.exc_req   = 1'b0;
    bus.busy      = 1'b0;
    bus.halt      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    bus.pc_cur = 32'h0;
    sb.push_back(mk(0, 0, 0, S_RUN, 32'h4, 1));
    @(negedge clk);
    g = obs();
    e = sb.pop_front();
    checks++;
    if (g[37:33] !== e[37:33] ||
        (e.care && g.nx !== e.nx)) begin
      errors++;
      $display("FAIL reset got %h exp %h", g, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_seq();
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.pc_cur = 32'h0;
      sb.push_back(mk(1, 0, 0, S_RUN, 32'h4, 1));
      @(negedge clk);
      g = obs();
      e = sb.pop_front();
      checks++;
      if (g[37:33] !== e[37:33] ||
          (e.care && g.nx !== e.nx)) begin
        errors++;
        $display("FAIL seq[%0d] got %h exp %h",
                 i, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 6; i++) begin
      idle();
      bus.pc_cur = 32'h100;
      case (i)
        0: begin
          bus.exc_req = 1'b1;
          bus.jr_en = 1'b1; bus.jr_target = 32'h1002;
          bus.br_taken = 1'b1; bus.br_target = 32'h2000;
          e = mk(1, 1, 0, S_RUN, 32'h4, 1);
        end
        1: begin
          bus.jr_en = 1'b1; bus.jr_target = 32'h1002;
          bus.br_taken = 1'b1; bus.br_target = 32'h2000;
          e = mk(1, 0, 0, S_RUN, 32'h1000, 1);
        end
        2: begin
          bus.eret = 1'b1; bus.epc_in = 32'h2003;
          bus.jr_en = 1'b1; bus.jr_target = 32'h1002;
          bus.j_en = 1'b1; bus.j_target = 32'h3000;
          e = mk(1, 0, 0, S_RUN, 32'h2000, 1);
        end
        3: begin
          bus.j_en = 1'b1; bus.j_target = 32'h3001;
          bus.br_taken = 1'b1; bus.br_target = 32'h2000;
          e = mk(1, 0, 0, S_RUN, 32'h3000, 1);
        end
        4: begin
          bus.br_taken = 1'b1; bus.br_target = 32'h4002;
          e = mk(1, 0, 0, S_RUN, 32'h4000, 1);
        end
        default: e = mk(1, 0, 0, S_RUN, 32'h104, 1);
      endcase
      sb.push_back(e);
      @(negedge clk);
      g = obs();
      e = sb.pop_front();
      checks++;
      if (g[37:33] !== e[37:33] ||
          (e.care && g.nx !== e.nx)) begin
        errors++;
        $display("FAIL prio[%0d] got %h exp %h",
                 i, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 7; i++) begin
      idle();
      bus.pc_cur = 32'h40;
      bus.busy = (i < 5);
      if (i == 0)      e = mk(0, 0, 0, S_RUN, 32'h44, 0);
      else if (i < 5)  e = mk(0, 0, 0, S_STL, 32'h44, 0);
      else if (i == 5) e = mk(1, 0, 0, S_STL, 32'h44, 1);
      else             e = mk(1, 0, 0, S_RUN, 32'h44, 1);
      sb.push_back(e);
      @(negedge clk);
      g = obs();
      e = sb.pop_front();
      checks++;
      if (g[37:33] !== e[37:33] ||
          (e.care && g.nx !== e.nx)) begin
        errors++;
        $display("FAIL stall[%0d] got %h exp %h",
                 i, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_queued();
    for (int i = 0; i < 7; i++) begin
      idle();
      bus.pc_cur = 32'h80;
      bus.busy = (i < 4);
      bus.exc_req = (i == 2);
      case (i)
        0:       e = mk(0, 0, 0, S_RUN, 32'h84, 0);
        5:       e = mk(1, 1, 0, S_TRP, 32'h4, 1);
        6:       e = mk(1, 0, 0, S_RUN, 32'h84, 1);
        default: e = mk(0, 0, 0, S_STL, 32'h84, 0);
      endcase
      sb.push_back(e);
      @(negedge clk);
      g = obs();
      e = sb.pop_front();
      checks++;
      if (g[37:33] !== e[37:33] ||
          (e.care && g.nx !== e.nx)) begin
        errors++;
        $display("FAIL queued[%0d] got %h exp %h",
                 i, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 67; i++) begin
      idle();
      bus.pc_cur = 32'h100;
      bus.busy = (i < 65);
      if (i == 0)
        e = mk(0, 0, 0, S_RUN, 32'h104, 0);
      else if (i < 65)
        e = mk(0, 0, (i == 64), S_STL, 32'h104, 0);
      else if (i == 65)
        e = mk(1, 1, 0, S_TRP, 32'h4, 1);
      else
        e = mk(1, 0, 0, S_RUN, 32'h104, 1);
      sb.push_back(e);
      @(negedge clk);
      g = obs();
      e = sb.pop_front();
      checks++;
      if (g[37:33] !== e[37:33] ||
          (e.care && g.nx !== e.nx)) begin
        errors++;
        $display("FAIL wdog[%0d] got %h exp %h",
                 i, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      idle();
      bus.pc_cur = 32'h200;
      case (i)
        0: begin
          bus.busy = 1'b1;
          e = mk(0, 0, 0, S_RUN, 32'h204, 0);
        end
        1: begin
          bus.exc_req = 1'b1;
          e = mk(1, 1, 0, S_STL, 32'h4, 1);
        end
        2: begin
          bus.j_en = 1'b1; bus.j_target = 32'h300;
          e = mk(1, 0, 0, S_RUN, 32'h300, 1);
        end
        3: begin
          bus.busy = 1'b1; bus.exc_req = 1'b1;
          e = mk(0, 0, 0, S_RUN, 32'h4, 0);
        end
        4: e = mk(0, 0, 0, S_STL, 32'h204, 0);
        5: e = mk(1, 1, 0, S_TRP, 32'h4, 1);
        default: e = mk(1, 0, 0, S_RUN, 32'h204, 1);
      endcase
      sb.push_back(e);
      @(negedge clk);
      g = obs();
      e = sb.pop_front();
      checks++;
      if (g[37:33] !== e[37:33] ||
          (e.care && g.nx !== e.nx)) begin
        errors++;
        $display("FAIL b2b[%0d] got %h exp %h",
                 i, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt_reset();
    for (int i = 0; i < 18; i++) begin
      idle();
      rst = 1'b0;
      bus.pc_cur = 32'h40;
      if (i == 0) begin
        bus.halt = 1'b1;
        e = mk(0, 0, 0, S_RUN, 32'h44, 0);
      end else if (i <= 10) begin
        bus.br_taken = 1'b1;
        bus.br_target = 32'h500;
        bus.busy = (i == 3);
        bus.exc_req = (i == 5);
        e = mk(0, 0, 0, S_HLT, 32'h44, 0);
      end else if (i == 11) begin
        rst = 1'b1;
        e = mk(0, 0, 0, S_RUN, 32'h44, 1);
      end else begin
        bus.pc_cur = 32'hFFFF_FFFC;
        case (i)
          12: e = mk(1, 0, 0, S_RUN, 32'h0, 1);
          13: begin
            bus.busy = 1'b1;
            e = mk(0, 0, 0, S_RUN, 32'h0, 0);
          end
          14: begin
            bus.busy = 1'b1; bus.exc_req = 1'b1;
            e = mk(0, 0, 0, S_STL, 32'h0, 0);
          end
          15: begin
            rst = 1'b1;
            e = mk(0, 0, 0, S_RUN, 32'h0, 1);
          end
          default: e = mk(1, 0, 0, S_RUN, 32'h0, 1);
        endcase
      end
      sb.push_back(e);
      @(negedge clk);
      g = obs();
      e = sb.pop_front();
      checks++;
      if (g[37:33] !== e[37:33] ||
          (e.care && g.nx !== e.nx)) begin
        errors++;
        $display("FAIL halt[%0d] got %h exp %h",
                 i, g, e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_priority();
    test_stall();
    test_queued();
    test_watchdog();
    test_back_to_back();
    test_halt_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
